// File: rtl/add_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl_if
// Bundles the operation request and result signals of add_seq_ctrl.
//
// Signals (direction as seen by the adder, i.e. the slave):
//   start  in   request a new operation (taken only while ready=1)
//   sub    in   0 = a+b, 1 = a-b
//   a, b   in   W-bit operands
//   ready  out  block is idle and will accept start
//   busy   out  operation in progress
//   done   out  one-cycle pulse, result valid from here on
//   sum    out  W-bit result
//   cout   out  final carry (subtract: 1 = no borrow)
//   ovf    out  two's-complement overflow of the full-width result
//
// Handshake: a request is a cycle where start=1 and ready=1 at a rising clock
// edge; the operands on a/b/sub at that edge are the ones used. start in any
// other cycle has no effect. Results on sum/cout/ovf become valid with done
// and stay put until the next request is taken.
// -----------------------------------------------------------------------------
interface add_seq_ctrl_if #(
    parameter int WORDS = 4,
    parameter int W     = 16 * WORDS
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
// Multi-word adder/subtractor that pushes a W = 16*WORDS bit operation through
// a single 16-bit carry-lookahead adder, one 16-bit beat per clock, least
// significant word first. Subtraction is a + ~b + 1.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          add_seq_ctrl_if.slave (start/sub/a/b in, ready/busy/done/
//                sum/cout/ovf out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// WORDS is meant to be 2..8.
// Timing: start taken at edge n -> beats at edges n+1..n+WORDS -> done high in
// the cycle after edge n+WORDS -> back in IDLE at edge n+WORDS+1.
// -----------------------------------------------------------------------------
module add_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    add_seq_ctrl_if.slave      bus,
    output logic [1:0]         o_dbg_state
);
    localparam int W  = 16 * WORDS;
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [BW-1:0]   r_beat;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;      // already inverted for subtraction
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic            w_last_beat;
    logic [BW+3:0]   w_lsb;
    logic [15:0]     w_cla_a;
    logic [15:0]     w_cla_b;
    logic [15:0]     w_cla_sum;
    logic            w_cla_cout;
    logic            w_ready;
    logic            w_busy;
    logic            w_done;

    assign w_last_beat = (r_beat == BW'(WORDS - 1));
    // Bit offset of the current 16-bit word: beat * 16.
    assign w_lsb       = {r_beat, 4'b0000};
    assign w_cla_a     = r_a[w_lsb +: 16];
    assign w_cla_b     = r_b[w_lsb +: 16];

    cla_16bit u_cla (
        .i_a    (w_cla_a),
        .i_b    (w_cla_b),
        .i_cin  (r_carry),
        .o_sum  (w_cla_sum),
        .o_cout (w_cla_cout)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_RUN;
            S_RUN:   if (w_last_beat) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_RUN:   w_busy  = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        // The +1 of two's-complement negation enters as the
                        // carry into beat 0.
                        r_carry <= bus.sub;
                        r_sum   <= '0;
                        r_beat  <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[w_lsb +: 16] <= w_cla_sum;
                    r_carry            <= w_cla_cout;
                    if (w_last_beat) begin
                        r_beat <= '0;
                        r_cout <= w_cla_cout;
                        // Overflow: operand signs (after inversion) agree but
                        // the result sign differs from them.
                        r_ovf  <= (r_a[W-1] ~^ r_b[W-1]) & (r_a[W-1] ^ w_cla_sum[15]);
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: begin
                    r_beat <= r_beat;
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// -----------------------------------------------------------------------------
// cla_16bit
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups with a
// second lookahead level across the groups.
//
// Ports:
//   i_a, i_b  16-bit addends
//   i_cin     carry in
//   o_sum     16-bit sum
//   o_cout    carry out of bit 15
// -----------------------------------------------------------------------------
module cla_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_bg;
    logic [3:0]  w_bp;
    logic [4:0]  w_bc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        // Group generate / propagate.
        assign w_bg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        assign w_bp[k] = &w_p[4*k +: 4];

        // Bit carries inside the group from the group carry-in.
        assign w_c[4*k]   = w_bc[k];
        assign w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_bc[k]);
        assign w_c[4*k+2] = w_g[4*k+1]
                          | (w_p[4*k+1] & w_g[4*k])
                          | (w_p[4*k+1] & w_p[4*k] & w_bc[k]);
        assign w_c[4*k+3] = w_g[4*k+2]
                          | (w_p[4*k+2] & w_g[4*k+1])
                          | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                          | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_bc[k]);
    end

    // Group carries, all computed directly from i_cin.
    assign w_bc[0] = i_cin;
    assign w_bc[1] = w_bg[0] | (w_bp[0] & i_cin);
    assign w_bc[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & i_cin);
    assign w_bc[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[2] & w_bp[1] & w_bp[0] & i_cin);
    assign w_bc[4] = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                   | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[3] & w_bp[2] & w_bp[1] & w_bp[0] & i_cin);

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_bc[4];

endmodule
